// File: rtl/mult_div_unit_pkg.sv
// Op and FSM state encodings shared by the decode stage and the multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers: SIZE+1 cycles from start edge to HI/LO update,
// o_done pulses the cycle after; i_start and MTHI/MTLO strobes are dropped while o_busy is high.
module mult_div_unit #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [SIZE-1:0] i_op_a,
  input  logic [SIZE-1:0] i_op_b,
  input  logic            i_hi_we,
  input  logic            i_lo_we,
  input  logic [SIZE-1:0] i_w_data,
  output logic            o_busy,
  output logic            o_done,
  output logic [SIZE-1:0] o_hi,
  output logic [SIZE-1:0] o_lo
);
  import mult_div_unit_pkg::*;

  localparam int CW = $clog2(SIZE + 1);

  state_e          state_q;
  op_e             op_q;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] a_q, b_q, acc_q, sh_q, hi_q, lo_q;
  logic            neg_q, neg_rem_q, b_zero_q, done_q;

  // Operand preparation: signed ops run on magnitudes, signs fixed up in FIX.
  op_e             op_in;
  logic            a_neg, b_neg;
  logic [SIZE-1:0] a_mag, b_mag;

  always_comb begin
    op_in = op_e'(i_op);
    a_neg = op_is_signed(op_in) & i_op_a[SIZE-1];
    b_neg = op_is_signed(op_in) & i_op_b[SIZE-1];
    a_mag = a_neg ? -i_op_a : i_op_a;
    b_mag = b_neg ? -i_op_b : i_op_b;
  end

  // One iteration step: acc_q holds the running high half (product) or partial remainder,
  // sh_q holds the multiplier being consumed or the dividend/quotient shift register.
  logic [SIZE:0]   add_sum, div_tmp;
  logic [SIZE-1:0] div_diff, acc_d, sh_d;
  logic            div_ge;

  always_comb begin
    add_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : {(SIZE+1){1'b0}});
    div_tmp  = {acc_q, sh_q[SIZE-1]};
    div_ge   = div_tmp >= {1'b0, b_q};
    div_diff = div_tmp[SIZE-1:0] - b_q;
    if (op_is_div(op_q)) begin
      acc_d = div_ge ? div_diff : div_tmp[SIZE-1:0];
      sh_d  = {sh_q[SIZE-2:0], div_ge};
    end else begin
      acc_d = add_sum[SIZE:1];
      sh_d  = {add_sum[0], sh_q[SIZE-1:1]};
    end
  end

  logic [2*SIZE-1:0] prod_fix;
  logic [SIZE-1:0]   hi_fix, lo_fix;

  always_comb begin
    prod_fix = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
    if (!op_is_div(op_q)) begin
      hi_fix = prod_fix[2*SIZE-1:SIZE];
      lo_fix = prod_fix[SIZE-1:0];
    end else if (b_zero_q) begin
      hi_fix = a_q;
      lo_fix = {SIZE{1'b1}};
    end else begin
      hi_fix = neg_rem_q ? -acc_q : acc_q;
      lo_fix = neg_q ? -sh_q : sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            op_q      <= op_in;
            a_q       <= i_op_a;
            b_q       <= b_mag;
            acc_q     <= '0;
            sh_q      <= a_mag;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            b_zero_q  <= (i_op_b == '0);
            cnt_q     <= '0;
            state_q   <= ST_ITER;
          end else begin
            if (i_hi_we) hi_q <= i_w_data;
            if (i_lo_we) lo_q <= i_w_data;
          end
        end
        ST_ITER: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(SIZE - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst, i_start, i_hi_we, i_lo_we;
  logic [1:0]  i_op;
  logic [31:0] i_op_a, i_op_b, i_w_data;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.SIZE(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
    .i_w_data(i_w_data), .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  // Returns {HI, LO} computed with native arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin sp = longint'(sa) * longint'(sb); return 64'(sp); end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; return up; end
      2'd2: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issues one operation from an idle cycle and waits (bounded) for o_done.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int lat, output int busy_cnt, output bit held);
    logic [31:0] hi0, lo0;
    hi0 = o_hi; lo0 = o_lo;
    i_start = 1'b1; i_op = op; i_op_a = a; i_op_b = b;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0; busy_cnt = 0; held = 1'b1;
    while (!o_done && lat < 100) begin
      if (o_busy) busy_cnt++;
      if (o_hi !== hi0 || o_lo !== lo0) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!o_done) lat = -1;
    hi = o_hi; lo = o_lo;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
    i_op = 2'd0; i_op_a = '0; i_op_b = '0; i_w_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
    n_tests++; if (o_hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", o_hi); end
    n_tests++; if (o_lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", o_lo); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] as  [5] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd100};
    logic [31:0] bs  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0};
    logic [31:0] ehi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h64};
    logic [31:0] elo [5] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] hi, lo;
    int lat, bc;
    bit held;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], hi, lo, lat, bc, held);
      n_tests++; if (hi !== ehi[i]) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", i, hi, ehi[i]); end
      n_tests++; if (lo !== elo[i]) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", i, lo, elo[i]); end
      n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 33", i, lat); end
      n_tests++; if (bc !== 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want 33", i, bc); end
      @(posedge clk); #1;
      n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width got %b want 0", i, o_done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    int lat, bc;
    bit held;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      exp = ref_model(op, a, b);
      do_op(op, a, b, hi, lo, lat, bc, held);
      n_tests++;
      if ({hi, lo} !== exp || lat !== 33 || !held) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got %h_%h lat=%0d held=%0d want %h_%h lat=33 held=1",
                 i, op, a, b, hi, lo, lat, held, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_mt_writes();
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_w_data = 32'hCAFE0001;
    @(posedge clk); #1;
    n_tests++; if (o_hi !== 32'hCAFE0001 || o_lo !== 32'hCAFE0001) begin n_fail++; $display("FAIL mt_both got %h_%h want cafe0001_cafe0001", o_hi, o_lo); end
    i_lo_we = 1'b0; i_w_data = 32'h0BAD0002;
    @(posedge clk); #1;
    n_tests++; if (o_hi !== 32'h0BAD0002 || o_lo !== 32'hCAFE0001) begin n_fail++; $display("FAIL mthi_only got %h_%h want 0bad0002_cafe0001", o_hi, o_lo); end
    i_hi_we = 1'b0; i_lo_we = 1'b1; i_w_data = 32'h00C0FFEE;
    @(posedge clk); #1;
    n_tests++; if (o_hi !== 32'h0BAD0002 || o_lo !== 32'h00C0FFEE) begin n_fail++; $display("FAIL mtlo_only got %h_%h want 0bad0002_00c0ffee", o_hi, o_lo); end
    i_lo_we = 1'b0;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b;
    logic [63:0] exp;
    int lat, extra_busy;
    a = $urandom; b = $urandom;
    exp = ref_model(2'd0, a, b);
    i_start = 1'b1; i_op = 2'd0; i_op_a = a; i_op_b = b;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0;
    while (!o_done && lat < 100) begin
      if (lat == 5) begin
        i_start = 1'b1; i_op = 2'd3; i_op_a = 32'd9; i_op_b = 32'd4;
        i_hi_we = 1'b1; i_w_data = 32'h1234;
      end else begin
        i_start = 1'b0; i_hi_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!o_done) lat = -1;
    n_tests++;
    if ({o_hi, o_lo} !== exp || lat !== 33) begin
      n_fail++;
      $display("FAIL busy_ignore got %h_%h lat=%0d want %h_%h lat=33", o_hi, o_lo, lat, exp[63:32], exp[31:0]);
    end
    extra_busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (o_busy) extra_busy++;
    end
    n_tests++; if (extra_busy !== 0) begin n_fail++; $display("FAIL busy_no_queue got %0d busy cycles want 0", extra_busy); end
  endtask

  task automatic test_start_priority();
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    int lat, bc;
    bit held;
    a = $urandom; b = $urandom_range(1, 1000);
    exp = ref_model(2'd3, a, b);
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_w_data = 32'h55555555;
    do_op(2'd3, a, b, hi, lo, lat, bc, held);
    i_hi_we = 1'b0; i_lo_we = 1'b0;
    n_tests++; if (!held) begin n_fail++; $display("FAIL start_priority_hold got held=0 want 1"); end
    n_tests++;
    if ({hi, lo} !== exp || lat !== 33) begin
      n_fail++;
      $display("FAIL start_priority_result got %h_%h lat=%0d want %h_%h lat=33", hi, lo, lat, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset_abort();
    int lat, dones, busys;
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_w_data = 32'h77777777;
    @(posedge clk); #1;
    i_hi_we = 1'b0; i_lo_we = 1'b0;
    i_start = 1'b1; i_op = 2'd2; i_op_a = $urandom; i_op_b = $urandom_range(1, 50000);
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_hi !== 32'h0 || o_lo !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_state got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", o_busy, o_done, o_hi, o_lo);
    end
    dones = 0; busys = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_done) dones++;
      if (o_busy) busys++;
    end
    n_tests++; if (dones !== 0 || busys !== 0) begin n_fail++; $display("FAIL abort_quiet got done=%0d busy=%0d want 0 0", dones, busys); end
    i_lo_we = 1'b1; i_w_data = 32'h0000ABCD;
    @(posedge clk); #1;
    i_lo_we = 1'b0;
    n_tests++; if (o_lo !== 32'h0000ABCD || o_hi !== 32'h0) begin n_fail++; $display("FAIL abort_mtlo got %h_%h want 00000000_0000abcd", o_hi, o_lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_writes();
    test_random();
    test_busy_ignore();
    test_start_priority();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter SIZE, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port i_op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-006 SHALL have port i_op_a  input  SIZE  operand A (rs value from register bank o_reg_A).
REQ-007 SHALL have port i_op_b  input  SIZE  operand B (rt value from register bank o_reg_B).
REQ-008 SHALL have port i_hi_we / i_lo_we  input  1 each  MTHI / MTLO write strobes.
REQ-009 SHALL have port i_w_data  input  SIZE  data for MTHI/MTLO.
REQ-010 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port o_done  output  1  registered single-cycle completion pulse.
REQ-012 SHALL have port o_hi / o_lo  output  SIZE each  HI and LO architectural registers (MFHI/MFLO source).

Function
REQ-013 SHALL implement FSM states IDLE, ITER, FIX; ITER->FIX after SIZE iterations, FIX->IDLE always.
REQ-014 SHALL, in IDLE with i_start=1, latch operands, op, sign flags and magnitudes (signed ops), clear the iteration counter, and enter ITER at that edge (E0).
REQ-015 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per ITER cycle, exactly SIZE steps (edges E1..E32 for SIZE=32).
REQ-016 SHALL, in FIX, apply two's-complement sign correction and write HI/LO at edge E33, asserting o_done for exactly the following cycle.
REQ-017 SHALL give multiply result HI:LO = full 2*SIZE-bit product, signed for MULT, unsigned for MULTU.
REQ-018 SHALL give divide result LO = quotient truncated toward zero and HI = remainder carrying dividend's sign (DIV), unsigned for DIVU.
REQ-019 SHALL, for divide by zero (both DIV and DIVU), produce HI = i_op_a and LO = all ones with normal latency.
REQ-020 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO = 0x80000000, HI = 0.
REQ-021 SHALL ignore i_start while o_busy=1; no queuing.
REQ-022 SHALL, in IDLE, write i_w_data to HI when i_hi_we=1 and to LO when i_lo_we=1 at the next edge; both may write in the same cycle.
REQ-023 SHALL ignore i_hi_we/i_lo_we while o_busy=1.
REQ-024 SHALL give i_start priority over i_hi_we/i_lo_we when both are asserted in IDLE; the write is dropped.
REQ-025 SHALL hold o_hi/o_lo stable (previous value) throughout ITER and FIX until the E33 update.

Reset
REQ-026 SHALL, when rst=1 at posedge clk, force state IDLE, counter 0, o_busy=0, o_done=0, o_hi=0, o_lo=0.
REQ-027 SHALL abort any operation in progress on reset; no o_done pulse and no HI/LO write for the aborted operation.
REQ-028 SHALL give rst priority over i_start and write strobes.

Structure
REQ-029 SHALL take op encodings (MULT/MULTU/DIV/DIVU) and FSM state encodings from the shared pipeline package also used by the decode stage.
REQ-030 SHALL be a single module with no sub-modules; datapath (accumulator, shift register, counter) and FSM in one file.

Verification
REQ-031 SHALL cover MULT 7 x 0xFFFFFFFD -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_done exactly 33 cycles after start edge, o_busy high 33 cycles.
REQ-032 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 SHALL cover DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 SHALL cover DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF, normal latency.
REQ-035 SHALL cover start asserted and i_hi_we=1 (data 0x1234) at cycle 5 of a busy MULT -> both ignored; result equals the first operation's only.
REQ-036 SHALL cover rst asserted at cycle 10 of a DIV -> next cycle IDLE, o_busy=0, HI=LO=0, no o_done; a following MTLO 0xABCD in IDLE -> o_lo=0xABCD next cycle.
